// File: rtl/riscv_isa_pkg.sv
// Shared RISC-V instruction-stream definitions: instruction size decode,
// the c.nop padding halfword and the packer/realigner residue state.
package riscv_isa_pkg;

    // c.nop, used to pad a lone trailing compressed instruction to a full word
    localparam logic [15:0] C_NOP = 16'h0001;

    // Residue state shared by the op packer and the fetch realigner
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } rlgn_state_t;

    // Instruction size in bytes from the low halfword: 2'b11 marks a 32-bit op
    function automatic logic [2:0] opsiz(input logic [15:0] op);
        return (op[1:0] == 2'b11) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/riscv_op_packer.sv
// riscv_op_packer: packs a handshaked stream of 16/32-bit RISC-V instructions
// into aligned 32-bit memory words with byte enables and an incrementing address.
// Optional compressed-instruction support is enabled by defining RISCV_PACKER_C_EN;
// without it every instruction must be 32-bit and anything else is dropped and
// flagged on the sticky err output.
module riscv_op_packer
    import riscv_isa_pkg::*;
#(
    parameter int             AW      = 32,
    parameter logic [AW-1:0]  ADR_RST = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ins_vld,
    output logic          ins_rdy,
    input  logic [31:0]   ins_dat,
    input  logic          flu_vld,
    output logic          flu_rdy,
    output logic          mem_vld,
    input  logic          mem_rdy,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_dat,
    output logic [3:0]    mem_ben,
    output logic          err
);

    logic        free;
    logic        ins_acc;
    logic        flu_acc;
    logic        is32;
    logic        ld;
    logic [31:0] ld_dat;
    logic [3:0]  ld_ben;

    // The output slot can take a new word when empty or being drained this cycle;
    // an instruction takes priority over a flush.
    assign free    = !mem_vld || mem_rdy;
    assign ins_rdy = free;
    assign flu_rdy = free && !ins_vld;
    assign ins_acc = ins_vld && ins_rdy;
    assign flu_acc = flu_vld && flu_rdy;
    assign is32    = (opsiz(ins_dat[15:0]) == 3'd4);

`ifdef RISCV_PACKER_C_EN

    rlgn_state_t state, state_nxt;
    logic [15:0] res, res_nxt;

    // Next-state and word assembly: combine the held halfword with incoming halves
    always_comb begin
        state_nxt = state;
        res_nxt   = res;
        ld        = 1'b0;
        ld_dat    = mem_dat;
        ld_ben    = mem_ben;
        if (ins_acc) begin
            case (state)
                EMPTY: begin
                    if (is32) begin
                        ld     = 1'b1;
                        ld_dat = ins_dat;
                        ld_ben = 4'b1111;
                    end else begin
                        res_nxt   = ins_dat[15:0];
                        state_nxt = HALF;
                    end
                end
                HALF: begin
                    ld     = 1'b1;
                    ld_dat = {ins_dat[15:0], res};
                    ld_ben = 4'b1111;
                    if (is32) begin
                        res_nxt = ins_dat[31:16];
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end else if (flu_acc && (state == HALF)) begin
            ld        = 1'b1;
            ld_dat    = {C_NOP, res};
            ld_ben    = 4'b0011;
            state_nxt = EMPTY;
        end
    end

    // Residue state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            res   <= '0;
        end else begin
            state <= state_nxt;
            res   <= res_nxt;
        end
    end

    assign err = 1'b0;

`else

    logic unused_flu;
    assign unused_flu = flu_vld ^ flu_acc;

    // Without compressed support only 32-bit instructions produce words
    always_comb begin
        ld     = ins_acc && is32;
        ld_dat = ins_dat;
        ld_ben = 4'b1111;
    end

    // Sticky flag for dropped compressed instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (ins_acc && !is32) begin
            err <= 1'b1;
        end
    end

`endif

    // Output word register and address counter; a new word may load while the old one drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_vld <= 1'b0;
            mem_dat <= '0;
            mem_ben <= '0;
            mem_adr <= ADR_RST;
        end else begin
            if (mem_vld && mem_rdy) begin
                mem_adr <= mem_adr + AW'(4);
            end
            if (ld) begin
                mem_vld <= 1'b1;
                mem_dat <= ld_dat;
                mem_ben <= ld_ben;
            end else if (mem_rdy) begin
                mem_vld <= 1'b0;
            end
        end
    end

endmodule
